// File: rtl/load_ext_pipe.sv
// Registered load extender for the MEM/WB boundary: picks a byte/half/word lane,
// zero/sign-extends it, and hands the result out through a 2-entry skid buffer.
module load_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    localparam int AW    = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AW-1:0]     in_addr_lo,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              mis;
    } beat_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q;
    beat_t  m_q, s_q, ext_d;
    logic   in_ready_q, out_valid_q;
    logic   acc, xfer;

    logic [DATA_W-1:0] byte_sh, half_sh;
    logic [AW-1:0]     half_addr;

    assign acc  = in_valid && in_ready_q;
    assign xfer = out_valid_q && out_ready;

    // Half lane is the byte address with bit 0 dropped; works for AW == 1 too.
    assign half_addr = in_addr_lo & ~(AW'(1));
    assign byte_sh   = in_data >> {in_addr_lo, 3'b000};
    assign half_sh   = in_data >> {half_addr, 3'b000};

    always_comb begin
        ext_d      = '0;
        ext_d.tag  = in_tag;
        case (in_op)
            3'b000: begin
                if (in_addr_lo != '0) ext_d.mis  = 1'b1;
                else                  ext_d.data = in_data;
            end
            3'b001: ext_d.data = {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b010: ext_d.data = {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
            3'b011: begin
                if (in_addr_lo[0]) ext_d.mis  = 1'b1;
                else               ext_d.data = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
            end
            3'b100: begin
                if (in_addr_lo[0]) ext_d.mis  = 1'b1;
                else               ext_d.data = {{(DATA_W-16){1'b0}}, half_sh[15:0]};
            end
            3'b101: ext_d.data = {in_data[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default: ext_d.data = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    m_q         <= ext_d;
                    state_q     <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: begin
                    if (acc && xfer) begin
                        m_q <= ext_d;
                    end else if (acc) begin
                        s_q        <= ext_d;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (xfer) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: if (xfer) begin
                    m_q        <= s_q;
                    state_q    <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = m_q.data;
    assign out_tag      = m_q.tag;
    assign out_misalign = m_q.mis;
endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: directed extension vectors, backpressure, flush, reset
// and a randomized run against a depth-2 FIFO reference model.
module tb_load_ext_pipe;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_misalign;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_addr_lo;
    logic [2:0]  in_op;
    logic [4:0]  in_tag, out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        m;
    } ent_t;

    ent_t q[$];

    load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr_lo(in_addr_lo), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(logic [31:0] d, logic [1:0] a, logic [2:0] op, logic [4:0] t);
        ent_t   e;
        longint v;
        int     sh;
        sh  = 8 * int'(a);
        e.t = t;
        e.m = 1'b0;
        v   = 0;
        case (op)
            3'd0: if (a != 0) e.m = 1'b1; else v = longint'(d);
            3'd1, 3'd2: begin
                v = longint'(d >> sh) % 256;
                if (op == 3'd1 && v >= 128) v = v - 256;
            end
            3'd3, 3'd4: begin
                if (a % 2 != 0) e.m = 1'b1;
                else begin
                    v = longint'(d >> sh) % 65536;
                    if (op == 3'd3 && v >= 32768) v = v - 65536;
                end
            end
            3'd5: v = (longint'(d) % 65536) * 65536;
            default: v = -1;
        endcase
        e.d = v[31:0];
        return e;
    endfunction

    // One clock edge; the reference FIFO follows the same edge.
    task automatic step();
        bit   acc, xf;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        xf  = out_ready && (q.size() > 0);
        e   = model(in_data, in_addr_lo, in_op, in_tag);
        @(posedge clk);
        if (!reset || flush) q.delete();
        else begin
            if (xf)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(logic [2:0] op, logic [1:0] a, logic [31:0] d, logic [4:0] t);
        in_valid = 1'b1; in_op = op; in_addr_lo = a; in_data = d; in_tag = t;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 2'd0, 32'h0, 5'd0); in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_checks++; if (out_data !== 32'h0 || out_tag !== 5'd0 || out_misalign !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs got %h/%h/%b want 0/0/0", out_data, out_tag, out_misalign); end
    endtask

    task automatic test_extend();
        logic [2:0]  vop [10] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd5, 3'd7, 3'd6, 3'd0, 3'd0};
        logic [1:0]  va  [10] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
        logic [31:0] vd  [10] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                                  32'h0000ABCD, 32'h80FF1234, 32'h12345678, 32'h80FF1234, 32'h80FF1234};
        logic [31:0] ed  [10] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h0,
                                  32'hABCD0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80FF1234, 32'h0};
        logic        em  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vop[i], va[i], vd[i], 5'(i + 3));
            step();
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1 || out_data !== ed[i] || out_misalign !== em[i] || out_tag !== 5'(i + 3)) begin
                n_fail++;
                $display("FAIL ext_vec%0d got v=%b d=%h m=%b t=%0d want v=1 d=%h m=%b t=%0d",
                         i, out_valid, out_data, out_misalign, out_tag, ed[i], em[i], i + 3);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(3'd0, 2'd0, 32'h11111111, 5'd1); step();
        drive(3'd0, 2'd0, 32'h22222222, 5'd2); step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        drive(3'd0, 2'd0, 32'h33333333, 5'd3); step();
        n_checks++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_data !== 32'h11111111) begin
            n_fail++; $display("FAIL bp_stall got r=%b t=%0d d=%h want r=0 t=1 d=11111111", in_ready, out_tag, out_data); end
        out_ready = 1'b1; step();
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got v=%b t=%0d r=%b want v=1 t=2 r=1", out_valid, out_tag, in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h33333333) begin
            n_fail++; $display("FAIL bp_third got v=%b t=%0d d=%h want v=1 t=3 d=33333333", out_valid, out_tag, out_data); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(3'd0, 2'd0, 32'hAAAA0001, 5'd4); step();
        drive(3'd0, 2'd0, 32'hAAAA0002, 5'd5); step();
        drive(3'd0, 2'd0, 32'h77777777, 5'd7); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        // Flush in ONE with a beat offered: that beat must be discarded too.
        drive(3'd0, 2'd0, 32'hAAAA0003, 5'd6); step();
        drive(3'd0, 2'd0, 32'h77777777, 5'd7); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_one%0d got v=%b t=%0d want v=0", i, out_valid, out_tag); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        out_ready = 1'b0;
        drive(3'd1, 2'd3, 32'h80FF1234, 5'd9); step();
        drive(3'd0, 2'd2, 32'h12345678, 5'd10); step();
        in_valid = 1'b0; reset = 1'b0; step(); reset = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'd0 || out_misalign !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got v=%b r=%b d=%h t=%0d m=%b want 0 1 0 0 0",
                               out_valid, in_ready, out_data, out_tag, out_misalign); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive(3'd0, 2'd0, d, 5'(i + 12)); step();
            n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'(i + 12) || out_data !== d || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream%0d got v=%b t=%0d d=%h r=%b want v=1 t=%0d d=%h r=1",
                                   i, out_valid, out_tag, out_data, in_ready, i + 12, d); end
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 2'($urandom), $urandom, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            step();
            flush = 1'b0;
            n_checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rnd%0d_hs got v=%b r=%b want occupancy %0d", i, out_valid, in_ready, q.size());
            end else if (q.size() != 0 && (out_data !== q[0].d || out_tag !== q[0].t || out_misalign !== q[0].m)) begin
                n_fail++; $display("FAIL rnd%0d_data got d=%h t=%0d m=%b want d=%h t=%0d m=%b",
                                   i, out_data, out_tag, out_misalign, q[0].d, q[0].t, q[0].m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_extend();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
